fifo_wr_arbiter: RTL and testbench
==================================

Name: fifo_wr_arbiter

Overview:
- Round-robin write arbiter that shares one FIFO write port between NUM_REQ producers.
- Sits in front of the fifo pointer controller and drives its wr input.
- Takes the FIFO full flag back and throttles writes against it.
- Bounds each producer to MAX_BURST consecutive accepted writes per grant, so no producer can starve the others.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 1..16.
- MAX_BURST, 4, maximum accepted writes per grant; must be >= 1.
- CNT_W, 16, width of the statistics counters (used only with the optional feature).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  NUM_REQ  per-producer write request; a producer holds it while it has data.
- full  input  1  FIFO full flag.
- gnt  output  NUM_REQ  registered one-hot grant; all-zero when idle.
- gnt_idx  output  $clog2(NUM_REQ) (min 1)  binary index of the current owner; 0 when idle.
- ack  output  NUM_REQ  one-hot; the owner's write is accepted this cycle.
- wr  output  1  write strobe to the FIFO.

Behaviour:
- Reset (synchronous): state=IDLE, gnt=0, gnt_idx=0, rr_ptr=0, burst_cnt=0.
- While rst=1, wr=0 and ack=0, forced combinationally.
- FSM states: IDLE, GRANT.
- IDLE:
  - gnt=0, wr=0.
  - If |req, pick the first set bit searching upward from rr_ptr, modulo NUM_REQ.
  - Next edge: gnt <= onehot(winner), gnt_idx <= winner, burst_cnt <= 0, state <= GRANT.
  - Latency: req rising at cycle t gives gnt at t+1; wr can assert at t+1.
- GRANT, combinational outputs:
  - wr = req[gnt_idx] & !full & !rst.
  - ack = gnt when wr=1, else 0.
- GRANT, on a cycle with wr=1: burst_cnt increments.
- GRANT, release condition: req[gnt_idx]=0, OR (wr=1 AND burst_cnt==MAX_BURST-1).
- GRANT, on release at the edge:
  - rr_ptr <= gnt_idx+1 mod NUM_REQ.
  - Re-arbitrate in the same edge over the current req, searching from gnt_idx+1. The old owner is therefore lowest priority, but may be re-granted if it is the only requester.
  - Winner found: stay in GRANT with the new owner, burst_cnt <= 0, no idle bubble.
  - No winner: state <= IDLE, gnt <= 0.
- full=1 in GRANT: wr=0, burst_cnt and owner held, no release unless the owner drops req. The grant is never revoked because of full alone.
- Producers may change req at any time. Only the owner's req bit affects wr; non-owner bits matter only at arbitration.
- Reset mid-burst: gnt, wr and ack are 0 the cycle after the reset edge; any partial burst is abandoned and arbitration restarts from index 0.
- NUM_REQ=1: requester 0 is always the winner, and it is re-granted every MAX_BURST writes.
- Index arithmetic wraps modulo NUM_REQ; NUM_REQ need not be a power of two.
- burst_cnt width is $clog2(MAX_BURST+1).

Optional Feature:
- Macro: FIFO_WR_ARB_STATS_EN.
- When defined, adds outputs wr_count[CNT_W-1:0] and stall_count[CNT_W-1:0]:
  - wr_count increments on every wr=1.
  - stall_count increments on every GRANT cycle where req[gnt_idx]=1 and full=1.
  - Both saturate at all-ones and clear on rst.
- When undefined, the ports and counters are absent and the behaviour is otherwise identical.

Decomposition:
- Shared package fifo_arb_pkg holds:
  - the state enum arb_state_t {IDLE, GRANT};
  - function rr_pick(req, start), which returns the index of the first set bit at or above start with wrap, plus a found flag.
- One sub-module is natural: rr_find_first, a pure combinational rotating priority encoder used by both IDLE and GRANT arbitration. The FSM, counters and stats stay in fifo_wr_arbiter.

Test Plan:
1. Reset, then req=4'b0100 held, full=0 -> gnt=4'b0100 one cycle after req; wr=1 for 4 cycles; gnt re-granted to requester 2 with no bubble, since it is the only requester.
2. req=4'b1111 constant, full=0 -> grant order 0,1,2,3,0; each owner gets exactly 4 acks; no idle cycle between owners.
3. Requester 1 owns with burst_cnt=2, full rises for 5 cycles -> wr=0 and gnt held for those 5 cycles; after full falls, 2 more writes complete, then the grant passes on.
4. Owner 3 drops req after 1 write while req[0]=1 -> next edge gnt=4'b0001, because the search from index 0 wraps; rr_ptr=0.
5. rst pulsed mid-burst of requester 2 with req=4'b0110 -> gnt=0 the next cycle; the first grant after reset goes to requester 1.
6. With FIFO_WR_ARB_STATS_EN, scenario 3 -> stall_count=5 and wr_count equals the total ack count; both read 0 after rst.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// Shared types and the rotating-priority pick helper for the FIFO
// write arbiter. No ports; imported by rr_find_first and fifo_wr_arbiter.
package fifo_arb_pkg;

  localparam int MAX_REQ = 16;

  typedef enum logic {
    IDLE,
    GRANT
  } arb_state_t;

  typedef struct packed {
    logic       found;
    logic [3:0] idx;
  } pick_t;

  // First set bit at or above start, wrapping modulo n (n <= 16).
  function automatic pick_t rr_pick(
    input logic [MAX_REQ-1:0] req,
    input logic [3:0]         start,
    input int                 n
  );
    pick_t p;
    int    j;
    p = '0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (i < n) begin
        j = int'(start) + i;
        if (j >= n) j = j - n;
        if (!p.found && req[j[3:0]]) begin
          p.found = 1'b1;
          p.idx   = j[3:0];
        end
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/rr_find_first.sv
// Rotating priority encoder: first requester at or above start.
// Ports: req, start in; found, idx out. Purely combinational.
module rr_find_first
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   start,
  output logic               found,
  output logic [IDX_W-1:0]   idx
);

  pick_t p;

  always_comb begin
    p = rr_pick(MAX_REQ'(req), 4'(start), NUM_REQ);
  end

  assign found = p.found;
  assign idx   = IDX_W'(p.idx);

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port, bursts capped at
// MAX_BURST writes per grant and throttled by the FIFO full flag.
// Ports: clk, rst (sync, high), req, full in; gnt, gnt_idx, ack, wr out.
// FIFO_WR_ARB_STATS_EN adds saturating wr_count and stall_count.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int MAX_BURST = 4,
  parameter int CNT_W     = 16,
  localparam int IDX_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int BC_W     = $clog2(MAX_BURST + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               full,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic [NUM_REQ-1:0] ack,
  output logic               wr
`ifdef FIFO_WR_ARB_STATS_EN
  ,
  output logic [CNT_W-1:0]   wr_count,
  output logic [CNT_W-1:0]   stall_count
`endif
);

  arb_state_t         state, state_n;
  logic [NUM_REQ-1:0] gnt_n;
  logic [IDX_W-1:0]   gnt_idx_n;
  logic [IDX_W-1:0]   rr_ptr, rr_ptr_n;
  logic [IDX_W-1:0]   nxt_idx, start, win;
  logic [BC_W-1:0]    burst_cnt, burst_n;
  logic               found, own_req, last, rel;

  assign nxt_idx = (gnt_idx == IDX_W'(NUM_REQ - 1))
                 ? '0 : gnt_idx + IDX_W'(1);

  // On release the old owner goes to the back of the queue.
  assign start = (state == GRANT) ? nxt_idx : rr_ptr;

  rr_find_first #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_find (
    .req   (req),
    .start (start),
    .found (found),
    .idx   (win)
  );

  assign own_req = req[gnt_idx];
  assign wr      = (state == GRANT) & own_req & ~full & ~rst;
  assign ack     = wr ? gnt : '0;
  assign last    = (burst_cnt == BC_W'(MAX_BURST - 1));
  assign rel     = ~own_req | (wr & last);

  always_comb begin
    state_n   = state;
    gnt_n     = gnt;
    gnt_idx_n = gnt_idx;
    rr_ptr_n  = rr_ptr;
    burst_n   = burst_cnt;
    unique case (state)
      IDLE: begin
        if (found) begin
          state_n   = GRANT;
          gnt_n     = NUM_REQ'(1) << win;
          gnt_idx_n = win;
          burst_n   = '0;
        end
      end
      GRANT: begin
        if (wr) burst_n = burst_cnt + BC_W'(1);
        if (rel) begin
          rr_ptr_n = nxt_idx;
          burst_n  = '0;
          if (found) begin
            gnt_n     = NUM_REQ'(1) << win;
            gnt_idx_n = win;
          end else begin
            state_n   = IDLE;
            gnt_n     = '0;
            gnt_idx_n = '0;
          end
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      gnt       <= '0;
      gnt_idx   <= '0;
      rr_ptr    <= '0;
      burst_cnt <= '0;
    end else begin
      state     <= state_n;
      gnt       <= gnt_n;
      gnt_idx   <= gnt_idx_n;
      rr_ptr    <= rr_ptr_n;
      burst_cnt <= burst_n;
    end
  end

`ifdef FIFO_WR_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_count    <= '0;
      stall_count <= '0;
    end else begin
      if (wr && wr_count != '1)
        wr_count <= wr_count + CNT_W'(1);
      if ((state == GRANT) && own_req && full
          && stall_count != '1)
        stall_count <= stall_count + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter (NUM_REQ=4, MAX_BURST=4).
// Vector table, directed corner sequences and random vs a queue model.
module tb_fifo_wr_arbiter;

  localparam int N  = 4;
  localparam int MB = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = '0;
  logic       full = 1'b0;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic [3:0] ack;
  logic       wr;
`ifdef FIFO_WR_ARB_STATS_EN
  logic [15:0] wr_count;
  logic [15:0] stall_count;
`endif

  fifo_wr_arbiter #(
    .NUM_REQ   (N),
    .MAX_BURST (MB),
    .CNT_W     (16)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .full    (full),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .ack     (ack),
    .wr      (wr)
`ifdef FIFO_WR_ARB_STATS_EN
    ,
    .wr_count    (wr_count),
    .stall_count (stall_count)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // Reference model: owner -1 means nobody holds the port.
  int m_own = -1;
  int m_cnt = 0;
  int m_ptr = 0;
  int m_wrc = 0;
  int m_stc = 0;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int pick(input logic [3:0] r, input int s);
    for (int k = 0; k < N; k++) begin
      int j;
      j = (s + k) % N;
      if (r[j]) return j;
    end
    return -1;
  endfunction

  // One clock: drive at negedge, check #1 later, advance the model.
  task automatic step(input logic r, input logic [3:0] q,
                      input logic f);
    logic [3:0] e_gnt;
    logic       e_wr;
    int         w;
    @(negedge clk);
    rst  = r;
    req  = q;
    full = f;
    #1;
    e_gnt = (m_own >= 0) ? 4'(1 << m_own) : 4'd0;
    e_wr  = !r && m_own >= 0 && q[m_own] && !f;
    check("model_gnt", 32'(gnt), 32'(e_gnt));
    check("model_idx", 32'(gnt_idx),
          32'((m_own >= 0) ? m_own : 0));
    check("model_wr", 32'(wr), 32'(e_wr));
    check("model_ack", 32'(ack), 32'(e_wr ? e_gnt : 4'd0));
    if (r) begin
      m_own = -1; m_cnt = 0; m_ptr = 0; m_wrc = 0; m_stc = 0;
    end else begin
      if (m_own >= 0 && q[m_own] && f) m_stc++;
      if (e_wr) m_wrc++;
      if (m_own < 0) begin
        w = pick(q, m_ptr);
        if (w >= 0) begin
          m_own = w;
          m_cnt = 0;
        end
      end else begin
        if (e_wr) m_cnt++;
        if (!q[m_own] || m_cnt == MB) begin
          m_ptr = (m_own + 1) % N;
          m_own = pick(q, m_ptr);
          m_cnt = 0;
        end
      end
    end
  endtask

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic       full;
    logic [3:0] gnt;
    logic       wr;
  } vec_t;

  vec_t tbl[12];
  int   acks[4];
  int   idle;

  initial begin
    tbl[0]  = '{1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0};
    tbl[1]  = '{1'b0, 4'b0100, 1'b0, 4'b0000, 1'b0};
    tbl[2]  = '{1'b0, 4'b0100, 1'b0, 4'b0100, 1'b1};
    tbl[3]  = '{1'b0, 4'b0100, 1'b0, 4'b0100, 1'b1};
    tbl[4]  = '{1'b0, 4'b0100, 1'b0, 4'b0100, 1'b1};
    tbl[5]  = '{1'b0, 4'b0100, 1'b0, 4'b0100, 1'b1};
    tbl[6]  = '{1'b0, 4'b0100, 1'b0, 4'b0100, 1'b1};
    tbl[7]  = '{1'b1, 4'b0000, 1'b0, 4'b0100, 1'b0};
    tbl[8]  = '{1'b0, 4'b1000, 1'b0, 4'b0000, 1'b0};
    tbl[9]  = '{1'b0, 4'b1000, 1'b0, 4'b1000, 1'b1};
    tbl[10] = '{1'b0, 4'b0001, 1'b0, 4'b1000, 1'b0};
    tbl[11] = '{1'b0, 4'b0001, 1'b0, 4'b0001, 1'b1};

    // Single requester regrant, reset force, wrap to index 0.
    for (int i = 0; i < 12; i++) begin
      step(tbl[i].rst, tbl[i].req, tbl[i].full);
      check($sformatf("tbl%0d_gnt", i), 32'(gnt), 32'(tbl[i].gnt));
      check($sformatf("tbl%0d_wr", i), 32'(wr), 32'(tbl[i].wr));
      check($sformatf("tbl%0d_ack", i), 32'(ack),
            32'(tbl[i].wr ? tbl[i].gnt : 4'd0));
    end

    // All four requesting: order 0,1,2,3,0, four acks each.
    step(1'b1, 4'b0000, 1'b0);
    step(1'b0, 4'b1111, 1'b0);
    for (int k = 0; k < 4; k++) acks[k] = 0;
    idle = 0;
    for (int k = 1; k <= 17; k++) begin
      step(1'b0, 4'b1111, 1'b0);
      check("rr_order", 32'(gnt_idx), 32'(((k - 1) / 4) % 4));
      if (gnt == 4'd0) idle++;
      if (k <= 16)
        for (int b = 0; b < 4; b++) acks[b] += int'(ack[b]);
    end
    for (int b = 0; b < 4; b++)
      check($sformatf("rr_acks%0d", b), 32'(acks[b]), 32'd4);
    check("rr_no_bubble", 32'(idle), 32'd0);

    // Full stall mid-burst of requester 1.
    step(1'b1, 4'b0000, 1'b0);
    step(1'b0, 4'b0110, 1'b0);
    step(1'b0, 4'b0110, 1'b0);
    step(1'b0, 4'b0110, 1'b0);
    for (int k = 0; k < 5; k++) begin
      step(1'b0, 4'b0110, 1'b1);
      check("stall_wr", 32'(wr), 32'd0);
      check("stall_gnt", 32'(gnt), 32'b0010);
    end
    for (int k = 0; k < 2; k++) begin
      step(1'b0, 4'b0110, 1'b0);
      check("resume_wr", 32'(wr), 32'd1);
      check("resume_gnt", 32'(gnt), 32'b0010);
    end
    step(1'b0, 4'b0110, 1'b0);
    check("pass_on_gnt", 32'(gnt), 32'b0100);
`ifdef FIFO_WR_ARB_STATS_EN
    check("stall_count", 32'(stall_count), 32'd5);
    check("wr_count", 32'(wr_count), 32'd4);
    step(1'b1, 4'b0000, 1'b0);
    step(1'b0, 4'b0000, 1'b0);
    check("stall_clr", 32'(stall_count), 32'd0);
    check("wr_clr", 32'(wr_count), 32'd0);
`endif

    // Reset in the middle of requester 2's burst.
    step(1'b1, 4'b0000, 1'b0);
    step(1'b0, 4'b0110, 1'b0);
    for (int k = 0; k < 5; k++) step(1'b0, 4'b0110, 1'b0);
    check("pre_rst_gnt", 32'(gnt), 32'b0100);
    step(1'b1, 4'b0110, 1'b0);
    check("in_rst_wr", 32'(wr), 32'd0);
    check("in_rst_ack", 32'(ack), 32'd0);
    step(1'b0, 4'b0110, 1'b0);
    check("post_rst_gnt", 32'(gnt), 32'd0);
    check("post_rst_wr", 32'(wr), 32'd0);
    step(1'b0, 4'b0110, 1'b0);
    check("first_after_rst", 32'(gnt), 32'b0010);

    // Random traffic against the model.
    for (int k = 0; k < 800; k++) begin
      step(($urandom % 64) == 0, 4'($urandom),
           ($urandom % 4) == 0);
`ifdef FIFO_WR_ARB_STATS_EN
      check("rnd_wr_count", 32'(wr_count), 32'(m_wrc - int'(wr)));
`endif
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
